// File: rtl/line_matrix_programmer.sv
// Programs the GPO line matrix from a per-output route table: reset pulse, then one select/setup/clock step per valid entry.
// Pass length 20+12*V cycles at defaults; start ignored while busy; optional readback via LINE_MATRIX_READBACK_EN.
module line_matrix_programmer #(
  parameter int NUM_IN       = 8,
  parameter int NUM_OUT      = 10,
  parameter int SEL_W        = 4,
  parameter int RST_CYCLES   = 8,
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             cfg_wr_en,
  input  logic [SEL_W-1:0] cfg_wr_addr,
  input  logic [SEL_W-1:0] cfg_wr_data,
  input  logic             cfg_clear,
  input  logic             start,
`ifdef LINE_MATRIX_READBACK_EN
  input  logic [SEL_W-1:0] cfg_rd_addr,
  output logic [SEL_W:0]   cfg_rd_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             matrix_clk,
  output logic             matrix_rstn,
  output logic [SEL_W-1:0] matrix_input_select,
  output logic [SEL_W-1:0] matrix_output_select
);

  localparam int MAX_A   = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
  localparam int MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_OUT + 1);
  localparam logic [SEL_W:0] NUM_IN_W  = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

  typedef enum logic [2:0] {IDLE, RESET, SCAN, SETUP, CLK_HI, CLK_LO, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [NUM_OUT-1:0] tbl_vld;
  logic [SEL_W-1:0] tbl_data [NUM_OUT];
  logic             cur_vld;
  logic [SEL_W-1:0] cur_data;

  always_comb begin
    cur_vld  = 1'b0;
    cur_data = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (idx == IW'(i)) begin
        cur_vld  = tbl_vld[i];
        cur_data = tbl_data[i];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      idx                  <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      matrix_clk           <= 1'b0;
      matrix_rstn          <= 1'b1;
      matrix_input_select  <= '0;
      matrix_output_select <= '0;
      tbl_vld              <= '0;
      for (int i = 0; i < NUM_OUT; i++) tbl_data[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RESET;
            busy        <= 1'b1;
            error       <= 1'b0;
            idx         <= '0;
            cnt         <= '0;
            matrix_rstn <= 1'b0;
          end
        end
        RESET: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state       <= SCAN;
            matrix_rstn <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCAN: begin
          if (idx == IW'(NUM_OUT)) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (cur_vld && ({1'b0, cur_data} < NUM_IN_W)) begin
            matrix_output_select <= SEL_W'(idx);
            matrix_input_select  <= cur_data;
            state                <= SETUP;
            cnt                  <= '0;
          end else begin
            if (cur_vld) error <= 1'b1;
            idx <= idx + 1'b1;
          end
        end
        SETUP: begin
          if (cnt == CW'(SETUP_CYCLES - 1)) begin
            state      <= CLK_HI;
            matrix_clk <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLK_HI: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            state      <= CLK_LO;
            matrix_clk <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLK_LO: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            state <= SCAN;
            idx   <= idx + 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          state                <= IDLE;
          done                 <= 1'b0;
          busy                 <= 1'b0;
          matrix_input_select  <= '0;
          matrix_output_select <= '0;
        end
        default: state <= IDLE;
      endcase

      // Table edits only in IDLE; placed after the FSM so a bad-address write beats a coincident start.
      if (state == IDLE) begin
        if (cfg_clear) begin
          tbl_vld <= '0;
          for (int i = 0; i < NUM_OUT; i++) tbl_data[i] <= '0;
        end else if (cfg_wr_en) begin
          if ({1'b0, cfg_wr_addr} < NUM_OUT_W) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (cfg_wr_addr == SEL_W'(i)) begin
                tbl_vld[i]  <= 1'b1;
                tbl_data[i] <= cfg_wr_data;
              end
            end
          end else begin
            error <= 1'b1;
          end
        end
      end
    end
  end

`ifdef LINE_MATRIX_READBACK_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cfg_rd_data <= '0;
    end else begin
      cfg_rd_data <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (cfg_rd_addr == SEL_W'(i)) cfg_rd_data <= {tbl_vld[i], tbl_data[i]};
      end
    end
  end
`endif

endmodule
